// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and colour-bar palette for pattern_display.
package vga_pkg;

    localparam int unsigned CNT_W        = 10;

    localparam int unsigned VGA_CLK_DIV  = 5;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SW     = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SW + VGA_H_BP;
    localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SW - 1;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SW     = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SW + VGA_V_BP;
    localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SW - 1;

    localparam int unsigned N_BARS    = 8;
    localparam int unsigned BAR_IDX_W = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE = rgb_t'(24'hFFFFFF);
    localparam rgb_t RGB_BLACK = rgb_t'(24'h000000);

    // Bars left to right
    localparam rgb_t BAR_COLORS [N_BARS] = '{
        rgb_t'(24'hFFFFFF),
        rgb_t'(24'hFFFF00),
        rgb_t'(24'h00FFFF),
        rgb_t'(24'h00FF00),
        rgb_t'(24'hFF00FF),
        rgb_t'(24'hFF0000),
        rgb_t'(24'h0000FF),
        rgb_t'(24'h000000)
    };

endpackage

// File: rtl/pattern_display_if.sv
// Video output bundle of pattern_display: pixel enable, counters, syncs and colour.
interface pattern_display_if;
    import vga_pkg::*;

    logic             PCK;
    logic [CNT_W-1:0] HCNT;
    logic [CNT_W-1:0] VCNT;
    logic             VGA_HSYNC;
    logic             VGA_VSYNC;
    logic             VGA_DISPLAY_EN;
    logic [7:0]       VGA_R;
    logic [7:0]       VGA_G;
    logic [7:0]       VGA_B;

    modport master (
        output PCK, HCNT, VCNT, VGA_HSYNC, VGA_VSYNC, VGA_DISPLAY_EN,
        output VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input PCK, HCNT, VCNT, VGA_HSYNC, VGA_VSYNC, VGA_DISPLAY_EN,
        input VGA_R, VGA_G, VGA_B
    );

endinterface

// File: rtl/pattern_display_syncgen.sv
// syncgen: horizontal/vertical counters advanced on the pixel enable, plus
// registered sync and display-enable decode (one pixel behind the counters).
module syncgen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SW     = VGA_H_SW,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SW     = VGA_V_SW,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pck,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SW + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SW - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SW - 1;

    localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C  = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] HS_END_C  = CNT_W'(HS_END);
    localparam logic [CNT_W-1:0] VS_BEG_C  = CNT_W'(VS_START);
    localparam logic [CNT_W-1:0] VS_END_C  = CNT_W'(VS_END);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             w_hwrap;
    logic             w_vwrap;

    assign w_hwrap = (r_hcnt == H_LAST_C);
    assign w_vwrap = (r_vcnt == V_LAST_C);

    // Raster position; the line counter steps only on the pixel that ends a line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_pck) begin
            if (w_hwrap) begin
                r_hcnt <= '0;
                r_vcnt <= w_vwrap ? '0 : r_vcnt + CNT_W'(1);
            end else begin
                r_hcnt <= r_hcnt + CNT_W'(1);
            end
        end
    end

    // Decode from the pre-increment counters, hence the one-pixel lag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
        end else if (i_pck) begin
            r_hsync <= !((r_hcnt >= HS_BEG_C) && (r_hcnt <= HS_END_C));
            r_vsync <= !((r_vcnt >= VS_BEG_C) && (r_vcnt <= VS_END_C));
            r_de    <= (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
        end
    end

    assign o_hcnt  = r_hcnt;
    assign o_vcnt  = r_vcnt;
    assign o_hsync = r_hsync;
    assign o_vsync = r_vsync;
    assign o_de    = r_de;

endmodule

// File: rtl/pattern_display.sv
// pattern_display: single-clock VGA colour-bar generator (pixel rate as a clock enable).
// Optional build macro PTN_BORDER_EN draws a one-pixel white frame around the active area.
module pattern_display
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SW     = VGA_H_SW,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SW     = VGA_V_SW,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic                SYSCLK,
    input  logic                RST,
    pattern_display_if.master   vga
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE_C  = DIV_W'(CLK_DIV - 2);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] BAR_W_C    = CNT_W'(H_ACTIVE / N_BARS);

    logic [DIV_W-1:0]     r_div;
    logic                 r_pck;
    rgb_t                 r_rgb;
    logic [CNT_W-1:0]     w_hcnt;
    logic [CNT_W-1:0]     w_vcnt;
    logic                 w_hsync;
    logic                 w_vsync;
    logic                 w_de;
    logic                 w_active;
    logic [BAR_IDX_W-1:0] w_bar_idx;
    rgb_t                 w_pix;

    // Pixel enable registered one count early so it is high exactly while r_div is at its last value
    always_ff @(posedge SYSCLK or negedge RST) begin
        if (!RST) begin
            r_div <= '0;
            r_pck <= 1'b0;
        end else begin
            r_div <= (r_div == DIV_LAST_C) ? '0 : r_div + DIV_W'(1);
            r_pck <= (r_div == DIV_PRE_C);
        end
    end

    syncgen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SW     (H_SW),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SW     (V_SW),
        .V_BP     (V_BP)
    ) u_syncgen (
        .i_clk   (SYSCLK),
        .i_rst_n (RST),
        .i_pck   (r_pck),
        .o_hcnt  (w_hcnt),
        .o_vcnt  (w_vcnt),
        .o_hsync (w_hsync),
        .o_vsync (w_vsync),
        .o_de    (w_de)
    );

    assign w_active  = (w_hcnt < H_ACT_C) && (w_vcnt < V_ACT_C);
    assign w_bar_idx = BAR_IDX_W'(w_hcnt / BAR_W_C);

    always_comb begin
        w_pix = BAR_COLORS[w_bar_idx];
`ifdef PTN_BORDER_EN
        if ((w_hcnt == '0) || (w_hcnt == H_ACT_C - CNT_W'(1)) ||
            (w_vcnt == '0) || (w_vcnt == V_ACT_C - CNT_W'(1))) begin
            w_pix = RGB_WHITE;
        end
`endif
    end

    // Colour sampled from the same counters as the enable so both share the one-pixel lag
    always_ff @(posedge SYSCLK or negedge RST) begin
        if (!RST) begin
            r_rgb <= RGB_BLACK;
        end else if (r_pck) begin
            r_rgb <= w_active ? w_pix : RGB_BLACK;
        end
    end

    assign vga.PCK            = r_pck;
    assign vga.HCNT           = w_hcnt;
    assign vga.VCNT           = w_vcnt;
    assign vga.VGA_HSYNC      = w_hsync;
    assign vga.VGA_VSYNC      = w_vsync;
    assign vga.VGA_DISPLAY_EN = w_de;
    assign vga.VGA_R          = r_rgb.r;
    assign vga.VGA_G          = r_rgb.g;
    assign vga.VGA_B          = r_rgb.b;

endmodule

// File: tb/tb_pattern_display.sv
// Directed bench for pattern_display: full-size timing/pattern on one instance,
// vertical timing on a shrunken-raster instance sharing the same clock.
module tb_pattern_display;

    logic SYSCLK;
    logic RST;
    logic RST_S;

    int n_checks;
    int n_errors;

    pattern_display_if vga_if ();
    pattern_display_if vga_s ();

    pattern_display u_dut (
        .SYSCLK (SYSCLK),
        .RST    (RST),
        .vga    (vga_if)
    );

    pattern_display #(
        .CLK_DIV  (2),
        .H_ACTIVE (16),
        .H_FP     (2),
        .H_SW     (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SW     (2),
        .V_BP     (1)
    ) u_small (
        .SYSCLK (SYSCLK),
        .RST    (RST_S),
        .vga    (vga_s)
    );

    initial SYSCLK = 1'b0;
    always #4 SYSCLK = ~SYSCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    function automatic logic [23:0] rgb();
        return {vga_if.VGA_R, vga_if.VGA_G, vga_if.VGA_B};
    endfunction

    // Stop on the sample where the DUT is about to consume pixel px, then step one edge
    task automatic wait_pix(input int px, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 5000 && !ok) begin
            if (vga_if.PCK === 1'b1 && vga_if.HCNT === 10'(px)) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        if (ok) tick();
    endtask

    initial begin
        int   n;
        int   de_hi;
        int   vmax;
        int   hmax;
        logic ok;
        logic [23:0] exp_639;

        n_checks = 0;
        n_errors = 0;
        RST      = 1'b0;
        RST_S    = 1'b0;

        // Reset held for 600 cycles
        repeat (600) tick();
        check("rst_pck",   32'(vga_if.PCK), 32'd0);
        check("rst_hcnt",  32'(vga_if.HCNT), 32'd0);
        check("rst_vcnt",  32'(vga_if.VCNT), 32'd0);
        check("rst_hsync", 32'(vga_if.VGA_HSYNC), 32'd1);
        check("rst_vsync", 32'(vga_if.VGA_VSYNC), 32'd1);
        check("rst_de",    32'(vga_if.VGA_DISPLAY_EN), 32'd0);
        check("rst_rgb",   32'(rgb()), 32'd0);

        // Release; the next rising edge is edge 1
        RST = 1'b1;
        repeat (4) tick();
        check("pck_before_edge5", 32'(vga_if.PCK), 32'd1);
        check("hcnt_before_edge5", 32'(vga_if.HCNT), 32'd0);
        tick();
        check("pck_after_edge5", 32'(vga_if.PCK), 32'd0);
        check("hcnt_after_first_pulse", 32'(vga_if.HCNT), 32'd1);
        check("de_first_pixel", 32'(vga_if.VGA_DISPLAY_EN), 32'd1);
        check("rgb_first_pixel", 32'(rgb()), 32'hFFFFFF);
        repeat (4) tick();
        check("pck_second_pulse", 32'(vga_if.PCK), 32'd1);
        check("hcnt_second_pulse", 32'(vga_if.HCNT), 32'd1);

        // First HSYNC fall: pixel 656 consumed on edge 5 + 656*5
        n     = 9;
        de_hi = 5;
        while (n < 5000 && vga_if.VGA_HSYNC !== 1'b0) begin
            tick();
            n++;
            if (vga_if.VGA_DISPLAY_EN === 1'b1) de_hi++;
        end
        check("hsync_first_fall_edge", 32'(n), 32'd3285);
        check("de_width_line0", 32'(de_hi), 32'd3200);

        n     = 0;
        de_hi = 0;
        while (n < 5000 && vga_if.VGA_HSYNC === 1'b0) begin
            tick();
            n++;
            if (vga_if.VGA_DISPLAY_EN === 1'b1) de_hi++;
        end
        check("hsync_low_sysclk", 32'(n), 32'd480);
        while (n < 8000 && vga_if.VGA_HSYNC !== 1'b0) begin
            tick();
            n++;
            if (vga_if.VGA_DISPLAY_EN === 1'b1) de_hi++;
        end
        check("hsync_period_sysclk", 32'(n), 32'd4000);
        check("de_width_line1", 32'(de_hi), 32'd3200);
        check("vcnt_line1", 32'(vga_if.VCNT), 32'd1);

        // Colour bars, checked on line 2 (away from the optional border rows)
        wait_pix(1, ok);
        check("wait_px1", 32'(ok), 32'd1);
        check("rgb_px1", 32'(rgb()), 32'hFFFFFF);
        check("vcnt_line2", 32'(vga_if.VCNT), 32'd2);
        wait_pix(80, ok);
        check("rgb_px80", 32'(rgb()), 32'hFFFF00);
        wait_pix(200, ok);
        check("rgb_px200", 32'(rgb()), 32'h00FFFF);
        wait_pix(240, ok);
        check("rgb_px240", 32'(rgb()), 32'h00FF00);
        wait_pix(320, ok);
        check("rgb_px320", 32'(rgb()), 32'hFF00FF);
        wait_pix(400, ok);
        check("rgb_px400", 32'(rgb()), 32'hFF0000);
        wait_pix(480, ok);
        check("rgb_px480", 32'(rgb()), 32'h0000FF);
`ifdef PTN_BORDER_EN
        exp_639 = 24'hFFFFFF;
`else
        exp_639 = 24'h000000;
`endif
        wait_pix(639, ok);
        check("rgb_px639", 32'(rgb()), 32'(exp_639));
        check("de_px639", 32'(vga_if.VGA_DISPLAY_EN), 32'd1);
        tick();
        check("hold_between_pck", 32'(rgb()), 32'(exp_639));
        wait_pix(640, ok);
        check("de_px640", 32'(vga_if.VGA_DISPLAY_EN), 32'd0);
        check("rgb_px640", 32'(rgb()), 32'd0);
        wait_pix(700, ok);
        check("rgb_px700_blank", 32'(rgb()), 32'd0);
        check("hsync_px700", 32'(vga_if.VGA_HSYNC), 32'd0);
        wait_pix(752, ok);
        check("hsync_px752", 32'(vga_if.VGA_HSYNC), 32'd1);
        wait_pix(799, ok);
        check("wait_px799", 32'(ok), 32'd1);
        check("hcnt_wrap", 32'(vga_if.HCNT), 32'd0);
        check("vcnt_step", 32'(vga_if.VCNT), 32'd3);

        // Mid-frame reset: asynchronous, between clock edges
        wait_pix(300, ok);
        #2;
        RST = 1'b0;
        #1;
        check("midrst_hcnt", 32'(vga_if.HCNT), 32'd0);
        check("midrst_vcnt", 32'(vga_if.VCNT), 32'd0);
        check("midrst_hsync", 32'(vga_if.VGA_HSYNC), 32'd1);
        check("midrst_de", 32'(vga_if.VGA_DISPLAY_EN), 32'd0);
        check("midrst_rgb", 32'(rgb()), 32'd0);
        repeat (20) tick();
        RST = 1'b1;
        n = 0;
        while (n < 5000 && vga_if.VGA_HSYNC !== 1'b0) begin
            tick();
            n++;
        end
        check("midrst_hsync_fall_edge", 32'(n), 32'd3285);
        check("midrst_vcnt_after", 32'(vga_if.VCNT), 32'd0);

        // Shrunken raster: 24 px x 8 lines, 2 SYSCLK per pixel -> 384 SYSCLK per frame
        tick();
        RST_S = 1'b1;
        n    = 0;
        hmax = 0;
        vmax = 0;
        while (n < 2000 && vga_s.VGA_VSYNC !== 1'b0) begin
            tick();
            n++;
        end
        check("small_vsync_seen", 32'(vga_s.VGA_VSYNC), 32'd0);
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (n < 2000 && vga_s.VGA_VSYNC === 1'b0) begin
                tick();
                n++;
            end
            check("small_vsync_low", 32'(n), 32'd96);
            while (n < 2000 && vga_s.VGA_VSYNC !== 1'b0) begin
                tick();
                n++;
                if (int'(vga_s.HCNT) > hmax) hmax = int'(vga_s.HCNT);
                if (int'(vga_s.VCNT) > vmax) vmax = int'(vga_s.VCNT);
            end
            check("small_vsync_period", 32'(n), 32'd384);
        end
        check("small_hcnt_max", 32'(hmax), 32'd23);
        check("small_vcnt_max", 32'(vmax), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
